pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Receiving end of the stall/flush request lines in the 5-stage RV32I pipeline.
- Consumes the load-use `stall_pipeline` request, the EX-stage branch/jump redirect and the data-memory busy signal, and converts them into per-stage register enables, bubble/flush controls and a PC redirect select.
- Contains a small FSM that freezes the pipe on memory wait and refills after redirect, covering instruction-memory fetch latency.
- Also contains a load-use overrun monitor.

Parameters:
- FETCH_LATENCY, 1, cycles after a redirect before IF delivers a valid instruction (legal 0..15).
- LU_STALL_MAX, 1, max consecutive non-frozen cycles `stall_pipeline` may stay high before overrun is flagged (legal 1..7).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall_pipeline  input  1  load-use stall request from hazard detection (ID vs EX).
- ex_branch_taken  input  1  level; taken branch/jump sits in EX; held while EX is frozen.
- dmem_busy  input  1  data memory not ready this cycle.
- pc_en  output  1  PC register write enable.
- pc_redirect  output  1  PC mux selects EX branch target.
- if_id_en  output  1  IF/ID register enable.
- if_id_flush  output  1  load NOP into IF/ID (dominates `if_id_en`).
- id_ex_en  output  1  ID/EX register enable.
- id_ex_flush  output  1  load bubble (all control zero) into ID/EX.
- ex_mem_en  output  1  EX/MEM enable.
- mem_wb_en  output  1  MEM/WB enable.
- lu_overrun  output  1  sticky error; set when the load-use stall exceeds LU_STALL_MAX.

Behaviour:
- Outputs are combinational from state and inputs so a stall takes effect in the detection cycle. State, counters and `lu_overrun` are registered.
- While rst is high:
  - all enables 0, `pc_redirect`=0, both flushes 1, `lu_overrun`=0.
  - state=RUN, refill counter 0, load-use counter 0.
- Priority in every state: dmem_busy > ex_branch_taken > stall_pipeline.
- FREEZE condition (`dmem_busy`=1, any state):
  - all enables 0, flushes 0, `pc_redirect`=0.
  - FSM state, refill counter and load-use counter hold.
  - Branch and stall requests are deferred; they are re-evaluated when `dmem_busy` drops.
- RUN, branch (`ex_branch_taken`=1, not busy):
  - `pc_en`=1, `pc_redirect`=1, `if_id_flush`=1, `id_ex_flush`=1, all other enables 1.
  - The load-use stall is ignored (the ID instruction is wrong-path).
  - Next state REFILL with counter=FETCH_LATENCY; if FETCH_LATENCY=0, stay in RUN.
- RUN, load-use (`stall_pipeline`=1, no branch, not busy):
  - `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
  - `ex_mem_en`=`mem_wb_en`=1, `id_ex_en`=1.
- RUN, idle: all enables 1, flushes 0.
- REFILL:
  - `pc_en`=1, `if_id_flush`=1, downstream enables 1; `stall_pipeline` is ignored.
  - Counter decrements each non-frozen cycle; when it reaches 1, next state RUN.
  - A new `ex_branch_taken` in REFILL acts as a redirect: outputs as in RUN-branch, counter reloads to FETCH_LATENCY.
- Load-use monitor:
  - Counter increments each non-frozen cycle in which `stall_pipeline`=1 is honoured; it clears otherwise.
  - When the counter exceeds LU_STALL_MAX, `lu_overrun` sets and stays set until rst.
- Counter widths: refill 4 bits, load-use 3 bits, saturating.
- Reset asserted mid-REFILL or mid-FREEZE returns to RUN immediately (async). First post-reset cycle behaves as RUN.

Optional Feature:
- Macro: PIPELINE_STALL_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, cleared on rst, wrapping modulo 2^32:
  - `perf_lu_cycles` counts honoured load-use stall cycles.
  - `perf_flush_events` counts redirect cycles.
  - `perf_freeze_cycles` counts `dmem_busy` cycles.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: RUN=2'd0, REFILL=2'd1.
  - Default FETCH_LATENCY and LU_STALL_MAX constants, shared with the fetch unit.
- Natural sub-module: `stall_perf_counters`, instantiated only under the macro.

Test Plan:
- Load-use: `stall_pipeline`=1 for 1 cycle in RUN → that cycle `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, `ex_mem_en`=1; next cycle all enables 1; `lu_overrun` stays 0.
- Redirect with FETCH_LATENCY=2: `ex_branch_taken` pulse → `pc_redirect`=1 and both flushes in that cycle, then `if_id_flush`=1 for exactly 2 more cycles, then RUN.
- Branch and load-use in the same cycle → redirect outputs only, `pc_en`=1, no load-use hold.
- Freeze: `dmem_busy` for 3 cycles during REFILL (counter=1) → all enables 0 for 3 cycles; the remaining refill cycle then completes after busy drops.
- Overrun: `stall_pipeline` held 2 cycles, LU_STALL_MAX=1 → `lu_overrun` rises after the second cycle and stays 1 until rst.
- Async rst asserted mid-REFILL → outputs at reset values without a clock edge; after release, RUN idle outputs; perf counters (macro on) read 0.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller and the fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REFILL = 2'd1
  } stall_state_e;

  // Defaults shared with the fetch unit so both sides agree on IMEM latency.
  localparam int unsigned FETCH_LATENCY_DEF = 1;
  localparam int unsigned LU_STALL_MAX_DEF  = 1;

  // Per-stage control bundle; field order is the order the top drives its ports.
  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_RESET  = '{pc_en:1'b0, pc_redirect:1'b0, if_id_en:1'b0, if_id_flush:1'b1,
                                        id_ex_en:1'b0, id_ex_flush:1'b1, ex_mem_en:1'b0, mem_wb_en:1'b0};
  localparam stage_ctl_t CTL_FREEZE = '0;
  localparam stage_ctl_t CTL_IDLE   = '{pc_en:1'b1, pc_redirect:1'b0, if_id_en:1'b1, if_id_flush:1'b0,
                                        id_ex_en:1'b1, id_ex_flush:1'b0, ex_mem_en:1'b1, mem_wb_en:1'b1};
  localparam stage_ctl_t CTL_BRANCH = '{pc_en:1'b1, pc_redirect:1'b1, if_id_en:1'b1, if_id_flush:1'b1,
                                        id_ex_en:1'b1, id_ex_flush:1'b1, ex_mem_en:1'b1, mem_wb_en:1'b1};
  localparam stage_ctl_t CTL_LOADUSE = '{pc_en:1'b0, pc_redirect:1'b0, if_id_en:1'b0, if_id_flush:1'b0,
                                         id_ex_en:1'b1, id_ex_flush:1'b1, ex_mem_en:1'b1, mem_wb_en:1'b1};
  localparam stage_ctl_t CTL_REFILL = '{pc_en:1'b1, pc_redirect:1'b0, if_id_en:1'b1, if_id_flush:1'b1,
                                        id_ex_en:1'b1, id_ex_flush:1'b0, ex_mem_en:1'b1, mem_wb_en:1'b1};

endpackage

// File: rtl/pipeline_stall_controller_perf_counters.sv
// Event counters for stall/flush/freeze activity (module stall_perf_counters).
// Latency: counts appear one cycle after the event cycle.
// Backpressure: none; counters wrap modulo 2^32.
// Ports: clk, rst (async active-high); lu_inc/flush_inc/freeze_inc event strobes;
//        perf_lu_cycles/perf_flush_events/perf_freeze_cycles 32-bit counts.
module stall_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        lu_inc,
  input  logic        flush_inc,
  input  logic        freeze_inc,
  output logic [31:0] perf_lu_cycles,
  output logic [31:0] perf_flush_events,
  output logic [31:0] perf_freeze_cycles
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cycles     <= '0;
      perf_flush_events  <= '0;
      perf_freeze_cycles <= '0;
    end else begin
      if (lu_inc)     perf_lu_cycles     <= perf_lu_cycles + 32'd1;
      if (flush_inc)  perf_flush_events  <= perf_flush_events + 32'd1;
      if (freeze_inc) perf_freeze_cycles <= perf_freeze_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Converts load-use, EX redirect and DMEM busy into per-stage enables/flushes and PC select.
// Latency: controls are combinational (act in the request cycle); FSM/counters/lu_overrun registered.
// Backpressure: dmem_busy freezes every stage and defers branch/stall requests until it drops.
// Ports: clk, rst (async active-high); stall_pipeline, ex_branch_taken, dmem_busy in;
//        pc_en, pc_redirect, if_id_en/flush, id_ex_en/flush, ex_mem_en, mem_wb_en, lu_overrun out.
// Optional: PIPELINE_STALL_PERF_CNT_EN adds perf_lu_cycles/perf_flush_events/perf_freeze_cycles.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned FETCH_LATENCY = FETCH_LATENCY_DEF,
  parameter int unsigned LU_STALL_MAX  = LU_STALL_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pipeline,
  input  logic        ex_branch_taken,
  input  logic        dmem_busy,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        lu_overrun
`ifdef PIPELINE_STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cycles,
  output logic [31:0] perf_flush_events,
  output logic [31:0] perf_freeze_cycles
`endif
);

  localparam logic [3:0] FETCH_LAT = 4'(FETCH_LATENCY);
  localparam logic [3:0] LU_MAX    = 4'(LU_STALL_MAX);

  stall_state_e state_q, state_d;
  logic [3:0]   refill_q, refill_d;
  logic [2:0]   lu_q, lu_d;
  logic         ovr_q, ovr_d;
  stage_ctl_t   ctl;

  always_comb begin
    ctl      = CTL_IDLE;
    state_d  = state_q;
    refill_d = refill_q;
    lu_d     = lu_q;
    ovr_d    = ovr_q;

    if (rst) begin
      ctl = CTL_RESET;
    end else if (dmem_busy) begin
      // Freeze: everything holds, pending requests are re-evaluated once busy drops.
      ctl = CTL_FREEZE;
    end else if (ex_branch_taken) begin
      // Redirect from RUN or REFILL; any load-use in ID is wrong-path and dropped.
      ctl  = CTL_BRANCH;
      lu_d = '0;
      if (FETCH_LAT == 4'd0) begin
        state_d  = ST_RUN;
        refill_d = '0;
      end else begin
        state_d  = ST_REFILL;
        refill_d = FETCH_LAT;
      end
    end else if (state_q == ST_REFILL) begin
      ctl  = CTL_REFILL;
      lu_d = '0;
      if (refill_q <= 4'd1) begin
        state_d  = ST_RUN;
        refill_d = '0;
      end else begin
        refill_d = refill_q - 4'd1;
      end
    end else if (stall_pipeline) begin
      ctl  = CTL_LOADUSE;
      lu_d = (lu_q == 3'd7) ? 3'd7 : lu_q + 3'd1;
      // Compare the unsaturated run length so LU_STALL_MAX=7 can still trip.
      if (({1'b0, lu_q} + 4'd1) > LU_MAX) ovr_d = 1'b1;
    end else begin
      lu_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      refill_q <= '0;
      lu_q     <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      lu_q     <= lu_d;
      ovr_q    <= ovr_d;
    end
  end

  assign {pc_en, pc_redirect, if_id_en, if_id_flush,
          id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en} = ctl;
  assign lu_overrun = ovr_q;

`ifdef PIPELINE_STALL_PERF_CNT_EN
  // Load-use is the only control pattern with the PC held but ID/EX still loading.
  stall_perf_counters u_perf (
    .clk                (clk),
    .rst                (rst),
    .lu_inc             (~ctl.pc_en & ctl.id_ex_en),
    .flush_inc          (ctl.pc_redirect),
    .freeze_inc         (dmem_busy & ~rst),
    .perf_lu_cycles     (perf_lu_cycles),
    .perf_flush_events  (perf_flush_events),
    .perf_freeze_cycles (perf_freeze_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized bench for pipeline_stall_controller against a cycle-level behavioural model.
// Latency: n/a. Backpressure: n/a.
module tb_pipeline_stall_controller;

  localparam int FL  = 2;
  localparam int MAX = 1;

  localparam logic [7:0] E_RESET  = 8'b0001_0100;
  localparam logic [7:0] E_FREEZE = 8'b0000_0000;
  localparam logic [7:0] E_IDLE   = 8'b1010_1011;
  localparam logic [7:0] E_BRANCH = 8'b1111_1111;
  localparam logic [7:0] E_LU     = 8'b0000_1111;
  localparam logic [7:0] E_REFILL = 8'b1011_1011;

  logic clk = 1'b0;
  logic rst, stall_pipeline, ex_branch_taken, dmem_busy;
  logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic lu_overrun;
`ifdef PIPELINE_STALL_PERF_CNT_EN
  logic [31:0] perf_lu_cycles, perf_flush_events, perf_freeze_cycles;
`endif

  pipeline_stall_controller #(.FETCH_LATENCY(FL), .LU_STALL_MAX(MAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_pipeline  (stall_pipeline),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_en           (pc_en),
    .pc_redirect     (pc_redirect),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .lu_overrun      (lu_overrun)
`ifdef PIPELINE_STALL_PERF_CNT_EN
    ,
    .perf_lu_cycles     (perf_lu_cycles),
    .perf_flush_events  (perf_flush_events),
    .perf_freeze_cycles (perf_freeze_cycles)
`endif
  );

  always #5 clk = ~clk;

  wire [7:0] ctl_obs = {pc_en, pc_redirect, if_id_en, if_id_flush,
                        id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

  int n_checks = 0;
  int n_pass   = 0;

  // Model: cycles of refill left, length of the current honoured load-use run, sticky error.
  int          m_refill;
  int          m_lu;
  logic        m_ovr;
  logic [31:0] m_pf_lu, m_pf_flush, m_pf_frz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_refill   = 0;
    m_lu       = 0;
    m_ovr      = 1'b0;
    m_pf_lu    = '0;
    m_pf_flush = '0;
    m_pf_frz   = '0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic b, input logic br, input logic st);
    logic [7:0] exp_ctl;
    dmem_busy       = b;
    ex_branch_taken = br;
    stall_pipeline  = st;
    @(negedge clk);
    if (b)                 exp_ctl = E_FREEZE;
    else if (br)           exp_ctl = E_BRANCH;
    else if (m_refill > 0) exp_ctl = E_REFILL;
    else if (st)           exp_ctl = E_LU;
    else                   exp_ctl = E_IDLE;
    check("ctl", {24'b0, ctl_obs}, {24'b0, exp_ctl});
    check("lu_overrun", {31'b0, lu_overrun}, {31'b0, m_ovr});
`ifdef PIPELINE_STALL_PERF_CNT_EN
    check("perf_lu", perf_lu_cycles, m_pf_lu);
    check("perf_flush", perf_flush_events, m_pf_flush);
    check("perf_freeze", perf_freeze_cycles, m_pf_frz);
`endif
    if (b) begin
      m_pf_frz++;
    end else if (br) begin
      m_refill = FL;
      m_lu     = 0;
      m_pf_flush++;
    end else if (m_refill > 0) begin
      m_refill--;
      m_lu = 0;
    end else if (st) begin
      m_lu++;
      m_pf_lu++;
      if (m_lu > MAX) m_ovr = 1'b1;
    end else begin
      m_lu = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Async reset taken mid-cycle: outputs must switch before any clock edge.
  task automatic async_reset();
    dmem_busy       = 1'b0;
    ex_branch_taken = 1'b0;
    stall_pipeline  = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_ctl", {24'b0, ctl_obs}, {24'b0, E_RESET});
    check("rst_ovr", {31'b0, lu_overrun}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    stall_pipeline  = 1'b0;
    ex_branch_taken = 1'b0;
    dmem_busy       = 1'b0;
    model_reset();
    #2;
    check("reset_ctl", {24'b0, ctl_obs}, {24'b0, E_RESET});
    check("reset_ovr", {31'b0, lu_overrun}, 32'd0);
    // Reset state must dominate even with requests asserted.
    stall_pipeline = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    check("reset_dominates", {24'b0, ctl_obs}, {24'b0, E_RESET});
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed scenarios.
    step(0, 0, 0);                                 // first cycle after reset: RUN idle
    step(0, 0, 1); step(0, 0, 0);                  // single load-use cycle
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);   // redirect + 2 refill
    step(0, 1, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 0);   // branch beats load-use
    step(0, 1, 0); step(0, 0, 0);                  // into REFILL with one cycle left
    step(1, 0, 0); step(1, 0, 1); step(1, 1, 0);   // freeze holds everything
    step(0, 0, 0); step(0, 0, 0);                  // last refill cycle, then RUN
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);   // overrun, sticky
    step(0, 1, 0);                                 // mid-REFILL async reset
    async_reset();
    step(0, 0, 0);

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 99) < 20),
             ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 35));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
